// File: rtl/oes_sort_engine.sv
// oes_sort_engine: frame sorter built on an odd-even transposition network.
// Collects DEPTH words over a valid/ready input. Sorts them in place, one network phase
// per clock, for DEPTH clocks. Then streams the sorted frame out over a valid/ready output.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        synchronous, active-high reset
//   in_valid_i   in_data_i carries a word
//   in_ready_o   engine accepts a word this cycle (high only while loading)
//   in_data_i    frame element
//   descend_i    sort order, captured with the first word of each frame
//   out_valid_o  out_data_o carries a sorted word
//   out_ready_i  consumer takes the word this cycle
//   out_data_o   sorted element
//   out_last_o   high with the final word of a frame
//   busy_o       high while sorting or draining
module oes_sort_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,  // even, >= 2
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              descend_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int unsigned     IdxW    = $clog2(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   phase_q, phase_d;
  logic              mode_q, mode_d;  // 1: descending
  logic [DATA_W-1:0] arr_q [DEPTH];
  logic [DATA_W-1:0] arr_d [DEPTH];

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] bias;
    bias           = '0;
    bias[DATA_W-1] = SIGNED;
    return (a ^ bias) > (b ^ bias);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    arr_d       = arr_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    busy_o      = 1'b0;

    unique case (state_q)
      StLoad: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          arr_d[idx_q] = in_data_i;
          idx_d        = idx_q + IdxW'(1);
          if (idx_q == '0) begin
            mode_d = descend_i;
          end
          if (idx_q == LastIdx) begin
            state_d = StSort;
            idx_d   = '0;
            phase_d = '0;
          end
        end
      end

      StSort: begin
        busy_o = 1'b1;
        // Even phases pair (0,1),(2,3)..; odd phases pair (1,2)..(DEPTH-3,DEPTH-2).
        // Pairs within one phase are disjoint, so every exchange reads arr_q.
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          if ((i % 2) == int'(phase_q[0])) begin
            if (mode_q ? greater(arr_q[i+1], arr_q[i]) : greater(arr_q[i], arr_q[i+1])) begin
              arr_d[i]   = arr_q[i+1];
              arr_d[i+1] = arr_q[i];
            end
          end
        end
        phase_d = phase_q + IdxW'(1);
        if (phase_q == LastIdx) begin
          state_d = StDrain;
          idx_d   = '0;
          phase_d = '0;
        end
      end

      StDrain: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_data_o  = arr_q[idx_q];
        out_last_o  = (idx_q == LastIdx);
        if (out_ready_i) begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            state_d = StLoad;
            idx_d   = '0;
          end
        end
      end

      default: begin
        state_d = StLoad;
        idx_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StLoad;
      idx_q   <= '0;
      phase_q <= '0;
      mode_q  <= 1'b0;
      arr_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      arr_q   <= arr_d;
    end
  end

endmodule
